// File: rtl/botassium_mem_arbiter.sv
// botassium_mem_arbiter
//   Two-master arbiter in front of a single-port 128 x 32 synchronous RAM
//   (registered address, unregistered q). One command is accepted per cycle.
//   The accepted command is registered onto the mem_* port for one cycle.
//   Read data comes back two edges after accept. A tag pipeline steers it to
//   the master that issued the read.
//
//   Ports
//     clk, reset               clock, asynchronous active-high reset
//     m0_* / m1_*              requester ports: address, byteenable, read,
//                              write, writedata in; waitrequest, readdata,
//                              readdatavalid out
//     mem_address/byteenable/chipselect/write/writedata   RAM command (registered)
//     mem_readdata             RAM q
//
//   Build option
//     BOTASSIUM_MEM_ARB_RR_EN  defined: on contention, the master not granted
//                              most recently wins. Undefined: m0 always wins
//                              contention.

// Per-master response register: loads RAM data when the tag pipeline says
// this master owns the read completing this edge, and holds it otherwise.
module botassium_mem_arbiter_rsp (
    input  logic        clk,
    input  logic        reset,
    input  logic        hit,
    input  logic [31:0] mem_readdata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= hit;
            if (hit) readdata <= mem_readdata;
        end
    end
endmodule

module botassium_mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  m0_address,
    input  logic [3:0]  m0_byteenable,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [6:0]  m1_address,
    input  logic [3:0]  m1_byteenable,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [6:0]  mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);
    localparam int NUM_M  = 2;
    localparam int STAGES = 2;

    logic [NUM_M-1:0] req;
    logic [NUM_M-1:0] grant;
    logic             acc;
    logic             sel;      // index of the granted master
    logic             sel_wr;   // read+write together counts as a write

    assign req = {m1_read | m1_write, m0_read | m0_write};

`ifdef BOTASSIUM_MEM_ARB_RR_EN
    logic last_grant;           // index of the master granted most recently
`endif

    // Grant is forced off during reset, so any requester sees waitrequest.
    always_comb begin
        grant = '0;
        if (!reset) begin
            if (&req) begin
`ifdef BOTASSIUM_MEM_ARB_RR_EN
                grant = last_grant ? 2'b01 : 2'b10;
`else
                grant = 2'b01;
`endif
            end else begin
                grant = req;
            end
        end
    end

    assign m0_waitrequest = req[0] & ~grant[0];
    assign m1_waitrequest = req[1] & ~grant[1];

    assign acc    = |grant;
    assign sel    = grant[1];
    assign sel_wr = sel ? m1_write : m0_write;

`ifdef BOTASSIUM_MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    last_grant <= 1'b1;
        else if (acc) last_grant <= sel;
    end
`endif

    // Tag pipeline: stage 0 marks the cycle the command sits on mem_*.
    // Stage 1 is the cycle RAM q is valid; the response registers load
    // at the edge that ends it.
    logic [STAGES-1:0] vld_pipe;
    logic [STAGES-1:0] own_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
            vld_pipe       <= '0;
            own_pipe       <= '0;
        end else begin
            mem_chipselect <= acc;
            mem_write      <= acc & sel_wr;
            if (acc) begin
                mem_address    <= sel ? m1_address    : m0_address;
                mem_byteenable <= sel ? m1_byteenable : m0_byteenable;
                mem_writedata  <= sel ? m1_writedata  : m0_writedata;
            end
            vld_pipe <= {vld_pipe[STAGES-2:0], acc & ~sel_wr};
            own_pipe <= {own_pipe[STAGES-2:0], sel};
        end
    end

    logic [NUM_M-1:0][31:0] rsp_data;
    logic [NUM_M-1:0]       rsp_vld;

    for (genvar i = 0; i < NUM_M; i++) begin : g_rsp
        botassium_mem_arbiter_rsp u_rsp (
            .clk           (clk),
            .reset         (reset),
            .hit           (vld_pipe[STAGES-1] & (own_pipe[STAGES-1] == 1'(i))),
            .mem_readdata  (mem_readdata),
            .readdata      (rsp_data[i]),
            .readdatavalid (rsp_vld[i])
        );
    end

    assign m0_readdata      = rsp_data[0];
    assign m1_readdata      = rsp_data[1];
    assign m0_readdatavalid = rsp_vld[0];
    assign m1_readdatavalid = rsp_vld[1];
endmodule
